// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX operand/control bus and EX/MEM outputs of the uP16 execute stage
interface ex_stage_if #(
    parameter int DSIZE = 16,
    parameter int RSIZE = 3
);
    logic             valid_in;
    logic [DSIZE-1:0] readData1;
    logic [DSIZE-1:0] readData2;
    logic [DSIZE-1:0] imm;
    logic             aluSrc;
    logic [3:0]       ALUOp;
    logic             memRead;
    logic             memWrite;
    logic             regWrite_in;
    logic             sel_mem2reg_in;
    logic [RSIZE-1:0] writeReg_in;

    logic [DSIZE-1:0] ALUResult_mem;
    logic [DSIZE-1:0] storeData;
    logic             memEnab;
    logic             memWriteEnab;
    logic [DSIZE-1:0] ALUResult;
    logic             sel_mem2reg;
    logic             regWrite;
    logic [RSIZE-1:0] writeReg;
    logic             stall;

    modport master (
        output valid_in, readData1, readData2, imm, aluSrc, ALUOp,
               memRead, memWrite, regWrite_in, sel_mem2reg_in, writeReg_in,
        input  ALUResult_mem, storeData, memEnab, memWriteEnab,
               ALUResult, sel_mem2reg, regWrite, writeReg, stall
    );

    modport slave (
        input  valid_in, readData1, readData2, imm, aluSrc, ALUOp,
               memRead, memWrite, regWrite_in, sel_mem2reg_in, writeReg_in,
        output ALUResult_mem, storeData, memEnab, memWriteEnab,
               ALUResult, sel_mem2reg, regWrite, writeReg, stall
    );
endinterface

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - uP16 execute stage: ALU, data-memory drive, EX/MEM register, iterative multiplier
module ex_stage #(
    parameter int DSIZE = 16,
    parameter int RSIZE = 3
) (
    input logic       Clk,
    input logic       Rst,
    ex_stage_if.slave ex
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_PASSB = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;

    localparam int CW = $clog2(DSIZE);

    logic [1:0]       state;
    logic [DSIZE-1:0] mcand;
    logic [DSIZE-1:0] mplier;
    logic [DSIZE-1:0] acc;
    logic [CW-1:0]    cnt;

    logic [DSIZE-1:0] op_b;
    logic [DSIZE-1:0] alu_out;
    logic [3:0]       shamt;
    logic             idle;
    logic             mul_issue;

    assign op_b      = ex.aluSrc ? ex.imm : ex.readData2;
    assign shamt     = op_b[3:0];
    assign idle      = (state == IDLE);
    assign mul_issue = idle && ex.valid_in && (ex.ALUOp == OP_MUL);

    always_comb begin
        alu_out = '0;
        case (ex.ALUOp)
            OP_ADD:   alu_out = ex.readData1 + op_b;
            OP_SUB:   alu_out = ex.readData1 - op_b;
            OP_AND:   alu_out = ex.readData1 & op_b;
            OP_OR:    alu_out = ex.readData1 | op_b;
            OP_XOR:   alu_out = ex.readData1 ^ op_b;
            OP_SLL:   alu_out = ex.readData1 << shamt;
            OP_SRL:   alu_out = ex.readData1 >> shamt;
            OP_SRA:   alu_out = DSIZE'($signed(ex.readData1) >>> shamt);
            OP_SLT:   alu_out = {{(DSIZE-1){1'b0}}, ($signed(ex.readData1) < $signed(op_b))};
            OP_PASSB: alu_out = op_b;
            default:  alu_out = '0;
        endcase
    end

    // In DONE the ID/EX register still holds the MUL, so the product replaces the ALU output.
    assign ex.ALUResult_mem = (state == DONE) ? acc : alu_out;
    assign ex.storeData     = ex.readData2;
    assign ex.memEnab       = ex.valid_in && (ex.memRead || ex.memWrite) && idle;
    assign ex.memWriteEnab  = ex.valid_in && ex.memWrite && idle;
    assign ex.stall         = mul_issue || (state == BUSY);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state  <= IDLE;
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_issue) begin
                        mcand  <= ex.readData1;
                        mplier <= op_b;
                        acc    <= '0;
                        cnt    <= '0;
                        state  <= BUSY;
                    end
                end
                BUSY: begin
                    if (mplier[0]) acc <= acc + mcand;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(DSIZE-1)) state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst || ex.stall || !ex.valid_in) begin
            ex.ALUResult   <= '0;
            ex.regWrite    <= 1'b0;
            ex.sel_mem2reg <= 1'b0;
            ex.writeReg    <= '0;
        end else begin
            ex.ALUResult   <= ex.ALUResult_mem;
            ex.regWrite    <= ex.regWrite_in;
            ex.sel_mem2reg <= ex.sel_mem2reg_in;
            ex.writeReg    <= ex.writeReg_in;
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - self-checking bench for ex_stage
module tb_ex_stage;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ex_stage_if #(.DSIZE(16), .RSIZE(3)) bus ();
    ex_stage #(.DSIZE(16), .RSIZE(3)) dut (.Clk(clk), .Rst(rst), .ex(bus));

    typedef struct {
        logic        v;
        logic [3:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] imm;
        logic        src;
        logic        mr;
        logic        mw;
        logic        rw;
        logic        sm;
        logic [2:0]  wr;
        logic [15:0] e_mem;
    } vec_t;

    int checks = 0;
    int failures = 0;
    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
        int sh;
        logic [31:0] ext;
        sh  = int'(b % 16);
        ext = {{16{a[15]}}, a};
        case (op)
            4'd0:    return a + b;
            4'd1:    return a - b;
            4'd2:    return a & b;
            4'd3:    return a | b;
            4'd4:    return a ^ b;
            4'd5:    return 16'(a * (32'd1 << sh));
            4'd6:    return 16'(a / (32'd1 << sh));
            4'd7:    return ext[15:0] >> 0 == 0 && sh == 0 ? a : 16'(ext >> sh);
            4'd8:    return (int'($signed(a)) < int'($signed(b))) ? 16'd1 : 16'd0;
            4'd9:    return b;
            4'd10:   return 16'(32'(a) * 32'(b));
            default: return 16'd0;
        endcase
    endfunction

    task automatic drive(input vec_t t);
        bus.valid_in       = t.v;
        bus.ALUOp          = t.op;
        bus.readData1      = t.a;
        bus.readData2      = t.b;
        bus.imm            = t.imm;
        bus.aluSrc         = t.src;
        bus.memRead        = t.mr;
        bus.memWrite       = t.mw;
        bus.regWrite_in    = t.rw;
        bus.sel_mem2reg_in = t.sm;
        bus.writeReg_in    = t.wr;
    endtask

    task automatic apply_vec(input vec_t t, input string name);
        drive(t);
        #2;
        chk({name, " ALUResult_mem"}, bus.ALUResult_mem, t.e_mem);
        chk({name, " storeData"}, bus.storeData, t.b);
        chk({name, " memEnab"}, bus.memEnab, t.v & (t.mr | t.mw));
        chk({name, " memWriteEnab"}, bus.memWriteEnab, t.v & t.mw);
        chk({name, " stall"}, bus.stall, 0);
        @(posedge clk); #1;
        chk({name, " ALUResult"}, bus.ALUResult, t.v ? t.e_mem : 16'd0);
        chk({name, " regWrite"}, bus.regWrite, t.v & t.rw);
        chk({name, " sel_mem2reg"}, bus.sel_mem2reg, t.v & t.sm);
        if (t.v) chk({name, " writeReg"}, bus.writeReg, t.wr);
    endtask

    task automatic mul_seq(input string name, input logic [15:0] a, input logic [15:0] b, input logic mr);
        int   stall_cycles = 0;
        int   edges = 0;
        int   bad = 0;
        logic done = 1'b0;
        vec_t t;
        t = '{1'b1, 4'd10, a, b, 16'h0, 1'b0, mr, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0};
        drive(t);
        #1;
        chk({name, " issue stall"}, bus.stall, 1);
        for (int i = 0; i < 40 && !done; i++) begin
            if (bus.stall) begin
                stall_cycles++;
                @(posedge clk); #1;
                edges++;
                if (bus.regWrite !== 1'b0 || bus.ALUResult !== 16'd0 ||
                    bus.memEnab !== 1'b0 || bus.memWriteEnab !== 1'b0) bad++;
            end else begin
                done = 1'b1;
                @(posedge clk); #1;
                edges++;
            end
        end
        chk({name, " stall cycles"}, stall_cycles, 17);
        chk({name, " edges to result"}, edges, 18);
        chk({name, " bubbles/enables while busy"}, bad, 0);
        chk({name, " product"}, bus.ALUResult, model(4'd10, a, b));
        chk({name, " regWrite"}, bus.regWrite, 1);
        chk({name, " writeReg"}, bus.writeReg, 5);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t t;
        //          v  op     a        b        imm      src mr mw rw sm wr    e_mem
        tbl[0]  = '{1, 4'd0,  16'h7FFF, 16'h0001, 16'h0000, 0, 0, 0, 1, 0, 3'd3, 16'h8000};
        tbl[1]  = '{1, 4'd0,  16'h0010, 16'h0000, 16'hFFFE, 1, 1, 0, 1, 1, 3'd2, 16'h000E};
        tbl[2]  = '{1, 4'd0,  16'h0020, 16'hBEEF, 16'h0004, 1, 0, 1, 0, 0, 3'd0, 16'h0024};
        tbl[3]  = '{1, 4'd8,  16'hFFFF, 16'h0001, 16'h0000, 0, 0, 0, 1, 0, 3'd1, 16'h0001};
        tbl[4]  = '{1, 4'd7,  16'h8000, 16'h0004, 16'h0000, 0, 0, 0, 1, 0, 3'd4, 16'hF800};
        tbl[5]  = '{1, 4'd1,  16'h0000, 16'h0001, 16'h0000, 0, 0, 0, 1, 0, 3'd5, 16'hFFFF};
        tbl[6]  = '{1, 4'd2,  16'hF0F0, 16'h0FF0, 16'h0000, 0, 0, 0, 1, 0, 3'd6, 16'h00F0};
        tbl[7]  = '{1, 4'd3,  16'hF000, 16'h000F, 16'h0000, 0, 0, 0, 1, 0, 3'd7, 16'hF00F};
        tbl[8]  = '{1, 4'd4,  16'hAAAA, 16'hFFFF, 16'h0000, 0, 0, 0, 1, 0, 3'd1, 16'h5555};
        tbl[9]  = '{1, 4'd5,  16'h0001, 16'h0013, 16'h0000, 0, 0, 0, 1, 0, 3'd2, 16'h0008};
        tbl[10] = '{1, 4'd6,  16'h8000, 16'h000F, 16'h0000, 0, 0, 0, 1, 0, 3'd3, 16'h0001};
        tbl[11] = '{1, 4'd8,  16'h0001, 16'hFFFF, 16'h0000, 0, 0, 0, 1, 0, 3'd4, 16'h0000};
        tbl[12] = '{1, 4'd9,  16'h1111, 16'h0000, 16'h1234, 1, 0, 0, 1, 0, 3'd5, 16'h1234};
        tbl[13] = '{1, 4'd12, 16'hFFFF, 16'hFFFF, 16'h0000, 0, 0, 0, 1, 0, 3'd6, 16'h0000};
        tbl[14] = '{0, 4'd0,  16'h0001, 16'h0001, 16'h0000, 0, 1, 0, 1, 1, 3'd7, 16'h0002};
        tbl[15] = '{1, 4'd5,  16'h00AB, 16'h0000, 16'h0010, 1, 0, 0, 1, 0, 3'd1, 16'h00AB};

        rst = 1'b1;
        t = '{0, 4'd0, 16'h0, 16'h0, 16'h0, 0, 0, 0, 0, 0, 3'd0, 16'h0};
        drive(t);
        repeat (2) @(posedge clk);
        #1;
        chk("reset ALUResult", bus.ALUResult, 0);
        chk("reset regWrite", bus.regWrite, 0);
        chk("reset sel_mem2reg", bus.sel_mem2reg, 0);
        chk("reset writeReg", bus.writeReg, 0);
        chk("reset stall", bus.stall, 0);
        rst = 1'b0;

        for (int i = 0; i < 16; i++) apply_vec(tbl[i], $sformatf("vec%0d", i));

        mul_seq("mul_a", 16'h0123, 16'h0045, 1'b1);
        mul_seq("mul_b2b", 16'h1234, 16'h0100, 1'b0);
        apply_vec(tbl[0], "add_after_mul");

        t = '{1, 4'd10, 16'h0007, 16'h0009, 16'h0, 0, 0, 0, 1, 0, 3'd2, 16'h0};
        drive(t);
        @(posedge clk); #1;
        repeat (4) @(posedge clk);
        #1;
        chk("busy5 stall", bus.stall, 1);
        rst = 1'b1;
        t = '{1, 4'd0, 16'h0002, 16'h0003, 16'h0, 0, 0, 0, 1, 0, 3'd1, 16'h0005};
        drive(t);
        @(posedge clk); #1;
        rst = 1'b0;
        chk("mid-mul reset stall", bus.stall, 0);
        chk("mid-mul reset ALUResult", bus.ALUResult, 0);
        chk("mid-mul reset regWrite", bus.regWrite, 0);
        apply_vec(t, "add_after_reset");

        for (int i = 0; i < 150; i++) begin
            t.v   = ($urandom_range(0, 7) != 0);
            t.op  = 4'($urandom_range(0, 15));
            if (t.op == 4'd10) t.op = 4'd9;
            t.a   = 16'($urandom);
            t.b   = 16'($urandom);
            t.imm = 16'($urandom);
            t.src = 1'($urandom);
            t.mr  = 1'($urandom);
            t.mw  = 1'($urandom);
            t.rw  = 1'($urandom);
            t.sm  = 1'($urandom);
            t.wr  = 3'($urandom);
            t.e_mem = model(t.op, t.a, t.src ? t.imm : t.b);
            apply_vec(t, $sformatf("rand%0d op%0d", i, t.op));
        end

        for (int i = 0; i < 4; i++)
            mul_seq($sformatf("rand_mul%0d", i), 16'($urandom), 16'($urandom), 1'($urandom));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
